// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolution block: control states and default widths.
package branch_resolve_pkg;

   localparam int DEF_DEPTH = 4;
   localparam int DEF_PTR_W = 2;
   localparam int DEF_CNT_W = 16;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

endpackage

// File: rtl/branch_resolve_if.sv
// Fetch/execute/predictor-update signal bundle for branch_resolve.
interface branch_resolve_if
   import branch_resolve_pkg::*;
#(
   parameter int PTR_W = DEF_PTR_W,
   parameter int CNT_W = DEF_CNT_W
) ();

   logic             pred_valid;
   logic             pred_taken;
   logic             pred_ready;
   logic             res_valid;
   logic             res_taken;
   logic             upd_branch;
   logic             upd_taken;
   logic             mispredict;
   logic             res_err;
   logic [PTR_W:0]   inflight;
   logic [CNT_W-1:0] cnt_branches;
   logic [CNT_W-1:0] cnt_mispred;

   modport master (
      output pred_valid, pred_taken, res_valid, res_taken,
      input  pred_ready, upd_branch, upd_taken, mispredict, res_err,
      input  inflight, cnt_branches, cnt_mispred
   );

   modport slave (
      input  pred_valid, pred_taken, res_valid, res_taken,
      output pred_ready, upd_branch, upd_taken, mispredict, res_err,
      output inflight, cnt_branches, cnt_mispred
   );

endinterface

// File: rtl/branch_resolve_pred_fifo.sv
// pred_fifo: DEPTH x 1-bit circular buffer of in-flight predictions with synchronous clear.
module pred_fifo
   import branch_resolve_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int PTR_W = DEF_PTR_W
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           push,
   input  logic           push_data,
   input  logic           pop,
   input  logic           clear,
   output logic [PTR_W:0] count,
   output logic           head_data,
   output logic           full,
   output logic           empty
);

   logic [DEPTH-1:0] storage;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Caller guarantees no push when full and no pop when empty; pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            storage[wr_ptr] <= push_data;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      end
   end

   assign head_data = storage[rd_ptr];
   assign full      = (count == (PTR_W+1)'(DEPTH));
   assign empty     = (count == '0);

endmodule

// File: rtl/branch_resolve.sv
// Resolves in-order predicted branches against execute outcomes and drives predictor updates.
// Statistics counters are built only when BRANCH_RESOLVE_STATS_EN is defined.
module branch_resolve
   import branch_resolve_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int PTR_W = DEF_PTR_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   branch_resolve_if.slave  bus
);

   state_t         state;
   state_t         state_next;
   logic           fifo_full;
   logic           fifo_empty;
   logic           fifo_head;
   logic [PTR_W:0] fifo_count;
   logic           ready;
   logic           do_push;
   logic           do_pop;
   logic           wrong;
   logic           empty_res;

   logic           upd_branch_q;
   logic           upd_taken_q;
   logic           mispredict_q;
   logic           res_err_q;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_RUN;
      else       state <= state_next;
   end

   // The flush cycle blocks both sides; a mispredicting pop always triggers it.
   always_comb begin
      state_next = ST_RUN;
      ready      = 1'b0;
      do_push    = 1'b0;
      do_pop     = 1'b0;
      wrong      = 1'b0;
      empty_res  = 1'b0;
      case (state)
         ST_RUN: begin
            ready     = !fifo_full;
            do_push   = bus.pred_valid && !fifo_full;
            do_pop    = bus.res_valid && !fifo_empty;
            empty_res = bus.res_valid && fifo_empty;
            wrong     = do_pop && (fifo_head != bus.res_taken);
            if (wrong) state_next = ST_FLUSH;
         end
         ST_FLUSH: state_next = ST_RUN;
         default:  state_next = ST_RUN;
      endcase
   end

   pred_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (do_push && !wrong),
      .push_data (bus.pred_taken),
      .pop       (do_pop),
      .clear     (wrong),
      .count     (fifo_count),
      .head_data (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         upd_branch_q <= 1'b0;
         upd_taken_q  <= 1'b0;
         mispredict_q <= 1'b0;
         res_err_q    <= 1'b0;
      end else begin
         upd_branch_q <= do_pop;
         upd_taken_q  <= do_pop && bus.res_taken;
         mispredict_q <= wrong;
         res_err_q    <= empty_res;
      end
   end

   assign bus.pred_ready = ready;
   assign bus.inflight   = fifo_count;
   assign bus.upd_branch = upd_branch_q;
   assign bus.upd_taken  = upd_taken_q;
   assign bus.mispredict = mispredict_q;
   assign bus.res_err    = res_err_q;

`ifdef BRANCH_RESOLVE_STATS_EN
   logic [CNT_W-1:0] cnt_branches_q;
   logic [CNT_W-1:0] cnt_mispred_q;

   // Both counters saturate at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_branches_q <= '0;
         cnt_mispred_q  <= '0;
      end else begin
         if (do_pop && (cnt_branches_q != '1)) cnt_branches_q <= cnt_branches_q + 1'b1;
         if (wrong && (cnt_mispred_q != '1))   cnt_mispred_q  <= cnt_mispred_q + 1'b1;
      end
   end

   assign bus.cnt_branches = cnt_branches_q;
   assign bus.cnt_mispred  = cnt_mispred_q;
`else
   assign bus.cnt_branches = {CNT_W{1'b0}};
   assign bus.cnt_mispred  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios then a random stream against a queue model.
module tb_branch_resolve;

   localparam int DEPTH    = 4;
   localparam int PTR_W    = 2;
   localparam int TB_CNT_W = 3;
   localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

   logic clk = 1'b0;
   logic reset;

   branch_resolve_if #(.PTR_W(PTR_W), .CNT_W(TB_CNT_W)) bus ();

   branch_resolve #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(TB_CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   bit q[$];
   bit mFlush;
   int mCntB, mCntM;
   bit eUpd, eTaken, eMis, eErr;

   task automatic check(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkOutput();
      int expB, expM;
`ifdef BRANCH_RESOLVE_STATS_EN
      expB = mCntB;
      expM = mCntM;
`else
      expB = 0;
      expM = 0;
`endif
      check("pred_ready", int'(bus.pred_ready), int'(!mFlush && q.size() < DEPTH));
      check("inflight", int'(bus.inflight), q.size());
      check("upd_branch", int'(bus.upd_branch), int'(eUpd));
      if (eUpd) check("upd_taken", int'(bus.upd_taken), int'(eTaken));
      check("mispredict", int'(bus.mispredict), int'(eMis));
      check("res_err", int'(bus.res_err), int'(eErr));
      check("cnt_branches", int'(bus.cnt_branches), expB);
      check("cnt_mispred", int'(bus.cnt_mispred), expM);
   endtask

   task automatic modelClear();
      q.delete();
      mFlush = 0;
      mCntB  = 0;
      mCntM  = 0;
      eUpd   = 0;
      eTaken = 0;
      eMis   = 0;
      eErr   = 0;
   endtask

   // Behavioural view: a list of outstanding guesses, a one-cycle blackout after a wrong guess.
   task automatic modelStep(input bit pv, input bit pt, input bit rv, input bit rt);
      bit ready, pop, wrongGuess;
      ready      = !mFlush && q.size() < DEPTH;
      pop        = rv && !mFlush && q.size() > 0;
      eErr       = rv && !mFlush && q.size() == 0;
      wrongGuess = pop && (q[0] != rt);
      eUpd       = pop;
      eTaken     = rt;
      eMis       = wrongGuess;
      if (pop) begin
         void'(q.pop_front());
         if (mCntB < CNT_MAX) mCntB++;
         if (wrongGuess && mCntM < CNT_MAX) mCntM++;
      end
      if (wrongGuess) begin
         q.delete();
         mFlush = 1;
      end else begin
         mFlush = 0;
         if (pv && ready) q.push_back(pt);
      end
   endtask

   task automatic applyStimulus(input bit pv, input bit pt, input bit rv, input bit rt);
      bus.pred_valid = pv;
      bus.pred_taken = pt;
      bus.res_valid  = rv;
      bus.res_taken  = rt;
      @(posedge clk);
      modelStep(pv, pt, rv, rt);
      #1;
      checkOutput();
   endtask

   task automatic applyReset(input bit pv, input bit rv);
      bus.pred_valid = pv;
      bus.pred_taken = 1'b1;
      bus.res_valid  = rv;
      bus.res_taken  = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      modelClear();
      #1;
      reset = 1'b0;
      checkOutput();
   endtask

   initial begin
      bit pv, pt, rv, rt;
      reset = 1'b1;
      bus.pred_valid = 1'b0;
      bus.pred_taken = 1'b0;
      bus.res_valid  = 1'b0;
      bus.res_taken  = 1'b0;
      modelClear();
      repeat (2) @(posedge clk);
      #1;
      applyReset(1'b0, 1'b0);

      $display("[TB] reset mid-stream with three entries queued");
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 1, 0, 0);
      applyReset(1'b1, 1'b1);

      $display("[TB] push T,N,T then resolve T,N,T");
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 1, 0, 0);
      applyStimulus(0, 0, 1, 1);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0);

      $display("[TB] fill, overflow push, push+pop while full");
      applyReset(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 1, 1);
      check("inflight_after_full_pushpop", int'(bus.inflight), 3);

      $display("[TB] mispredict flush");
      applyReset(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 1, 1, 0);
      check("flush_pred_ready", int'(bus.pred_ready), 0);
      applyStimulus(1, 1, 1, 1);
      applyStimulus(0, 0, 0, 0);

      $display("[TB] resolve with empty queue");
      applyReset(1'b0, 1'b0);
      applyStimulus(0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0);

      $display("[TB] counter saturation");
      applyReset(1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, i[0], 0, 0);
         applyStimulus(0, 0, 1, i[0]);
      end
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 1, 0, 0);
         applyStimulus(0, 0, 1, 0);
      end

      $display("[TB] random stream");
      applyReset(1'b0, 1'b0);
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 79) == 0) begin
            applyReset($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
         end else begin
            pv = ($urandom_range(0, 99) < 60);
            pt = $urandom_range(0, 1) == 1;
            rv = ($urandom_range(0, 99) < 45);
            if (q.size() > 0 && $urandom_range(0, 3) != 0) rt = q[0];
            else rt = $urandom_range(0, 1) == 1;
            applyStimulus(pv, pt, rv, rt);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
